patch_embed_acc_writer: RTL
===========================

Name: patch_embed_acc_writer

Overview:
- Upstream neighbour of the patch-embed output SRAM.
- Consumes a stream of signed activation/weight pairs from the patch-embed datapath and accumulates TAPS products per output element.
- Writes each finished element into the output SRAM through its single-element write port (w_en, ch_addr, addr, data_in).
- Output order: channel-major, pixel raster order inside each channel.

Parameters:
- bit_width, 30, accumulator and SRAM element width
- in_width, 8, signed activation and weight width
- channels, 64, output channels per frame
- size, 27, output feature map side (size*size pixels per channel)
- taps, 48, products per output element (4x4 kernel x 3 input channels)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins a frame
- in_valid  in  1  act/wgt pair valid
- in_ready  out  1  block accepts a pair this cycle
- act  in  in_width  signed activation
- wgt  in  in_width  signed weight
- w_en  out  1  SRAM write enable
- ch_addr  out  $clog2(channels)  SRAM channel address
- addr  out  $clog2(size*size)  SRAM element address
- data_in  out  bit_width  SRAM write data (accumulated result)
- busy  out  1  frame in progress
- frame_done  out  1  single-cycle pulse after last write

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high: the reset port is sampled on the rising edge of clk.
- Reset values:
  - FSM = IDLE.
  - in_ready, w_en, busy, frame_done = 0.
  - ch_addr, addr, data_in = 0.
  - Accumulator = 0; tap, pixel and channel counters = 0.
- FSM states:
  - IDLE: waits for start. On start, clear all counters and the accumulator, go to ACC.
  - ACC: in_ready = 1. On each handshake (in_valid & in_ready):
    - acc <= acc + sext(act*wgt); the product is a full 2*in_width signed value, sign-extended to bit_width.
    - Two's-complement wrap; no saturation. Defaults cannot overflow: 48 * 2^14 < 2^29.
    - On the handshake where tap == taps-1, go to WRITE. Otherwise tap increments.
  - WRITE: exactly one cycle.
    - w_en = 1, data_in = acc, ch_addr = channel counter, addr = pixel counter; all registered outputs.
    - in_ready = 0.
    - Next cycle: acc = 0, tap = 0.
    - Pixel counter increments. When it wraps from size*size-1 to 0, the channel counter increments.
    - If the write was (channels-1, size*size-1), go to DONE; otherwise go to ACC.
  - DONE: frame_done = 1 for one cycle, busy = 0, then IDLE.
- Latency: w_en asserts the cycle after the last tap handshake. Throughput is taps+1 cycles per element when in_valid is held high.
- busy = 1 in ACC and WRITE.
- w_en is 0 in every state except WRITE.
- ch_addr/addr hold their last value when w_en = 0.
- start is ignored while busy. start arriving in the DONE cycle is also ignored.
- in_valid while not in ACC: not accepted (in_ready = 0); the upstream holds the data.
- A reset mid-frame aborts immediately: no partial write, state = IDLE, all counters zero. SRAM contents are not touched by this block.
- Total writes per frame = channels*size*size. No element is written twice.

Decomposition:
- Shared package patch_embed_pkg:
  - FSM state enum (IDLE, ACC, WRITE, DONE).
  - Default constants: OUT_BW=30, IN_BW=8, OUT_CH=64, OUT_SIZE=27, TAPS=48.
  - Localparams derived from them: CH_AW, PIX_AW, TAP_W.
- One natural sub-module: mac_accum. Holds the signed multiply, sign extension and accumulate register, with clear and enable inputs.
- FSM and address counters stay in the top level.

Test Plan:
1. Reset, then idle 5 cycles -> all outputs 0, in_ready=0, no w_en.
2. Small config (channels=2, size=2, taps=4). start, stream act=3, wgt=-2 every cycle -> 8 writes with data_in = -24 (sign-extended). Addresses in order (0,0),(0,1),(0,2),(0,3),(1,0)..(1,3). frame_done one cycle after the 8th write. Each w_en exactly 1 cycle after the 4th tap.
3. Extremes (default params): act=-128, wgt=-128 for 48 taps -> data_in = 786432. act=127, wgt=-128 -> data_in = -780288.
4. in_valid toggled randomly at 50% -> identical results and addresses to scenario 2. in_ready=0 during WRITE; no tap lost or duplicated.
5. start pulsed mid-frame and in the DONE cycle -> ignored; write count stays channels*size*size.
6. reset asserted after 3 writes in the middle of an element -> next cycle in IDLE with w_en=0. A following start restarts at (0,0) with a cleared accumulator.

Source files
------------

// File: rtl/patch_embed_pkg.sv
// Shared types and default sizing for the patch-embed output writer.
package patch_embed_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int unsigned OUT_BW   = 30;
    localparam int unsigned IN_BW    = 8;
    localparam int unsigned OUT_CH   = 64;
    localparam int unsigned OUT_SIZE = 27;
    localparam int unsigned TAPS     = 48;

    localparam int unsigned CH_AW  = $clog2(OUT_CH);
    localparam int unsigned PIX_AW = $clog2(OUT_SIZE * OUT_SIZE);
    localparam int unsigned TAP_W  = $clog2(TAPS);

    // Counter/address width that stays at least one bit for degenerate sizes.
    function automatic int unsigned addr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/patch_embed_acc_writer_mac_accum.sv
// Signed multiply-accumulate with synchronous clear; exposes the next sum.
module mac_accum
    import patch_embed_pkg::*;
#(
    parameter int unsigned acc_w = OUT_BW,
    parameter int unsigned in_w  = IN_BW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic [in_w-1:0]   a,
    input  logic [in_w-1:0]   b,
    output logic [acc_w-1:0]  acc_nxt_c
);

    // acc_w must exceed the full product width so sign extension is meaningful.
    localparam int unsigned PROD_W = 2 * in_w;

    logic [PROD_W-1:0] a_ext_c;
    logic [PROD_W-1:0] b_ext_c;
    logic [PROD_W-1:0] prod_c;
    logic [acc_w-1:0]  prod_ext_c;
    logic [acc_w-1:0]  acc_q;
    logic [acc_w-1:0]  acc_d;

    // Full-width signed product, sign-extended, added with two's-complement wrap.
    always_comb begin
        a_ext_c    = {{in_w{a[in_w-1]}}, a};
        b_ext_c    = {{in_w{b[in_w-1]}}, b};
        prod_c     = a_ext_c * b_ext_c;
        prod_ext_c = {{(acc_w - PROD_W){prod_c[PROD_W-1]}}, prod_c};
        acc_nxt_c  = acc_q + prod_ext_c;
        acc_d      = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_nxt_c;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/patch_embed_acc_writer.sv
// Accumulates TAPS act*wgt products per output element and writes each
// finished element to the output SRAM in channel-major, raster order.
module patch_embed_acc_writer
    import patch_embed_pkg::*;
#(
    parameter int unsigned bit_width = OUT_BW,
    parameter int unsigned in_width  = IN_BW,
    parameter int unsigned channels  = OUT_CH,
    parameter int unsigned size      = OUT_SIZE,
    parameter int unsigned taps      = TAPS
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [in_width-1:0]               act,
    input  logic [in_width-1:0]               wgt,
    output logic                              w_en,
    output logic [addr_w(channels)-1:0]       ch_addr,
    output logic [addr_w(size*size)-1:0]      addr,
    output logic [bit_width-1:0]              data_in,
    output logic                              busy,
    output logic                              frame_done
);

    localparam int unsigned NPIX   = size * size;
    localparam int unsigned CH_W   = addr_w(channels);
    localparam int unsigned PIX_W  = addr_w(NPIX);
    localparam int unsigned TAP_CW = addr_w(taps);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ACC   = ACC;
    localparam logic [1:0] ST_WRITE = WRITE;
    localparam logic [1:0] ST_DONE  = DONE;

    localparam logic [TAP_CW-1:0] TAP_LAST = TAP_CW'(taps - 1);
    localparam logic [PIX_W-1:0]  PIX_LAST = PIX_W'(NPIX - 1);
    localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(channels - 1);

    logic [1:0]           state_q,      state_d;
    logic [TAP_CW-1:0]    tap_q,        tap_d;
    logic [PIX_W-1:0]     pix_q,        pix_d;
    logic [CH_W-1:0]      ch_q,         ch_d;
    logic                 in_ready_q,   in_ready_d;
    logic                 w_en_q,       w_en_d;
    logic                 busy_q,       busy_d;
    logic                 frame_done_q, frame_done_d;
    logic [CH_W-1:0]      ch_addr_q,    ch_addr_d;
    logic [PIX_W-1:0]     addr_q,       addr_d;
    logic [bit_width-1:0] data_in_q,    data_in_d;

    logic                 hs_c;
    logic                 mac_clr_c;
    logic                 mac_en_c;
    logic [bit_width-1:0] acc_nxt_c;

    // Product accumulator for the element currently being built.
    mac_accum #(
        .acc_w (bit_width),
        .in_w  (in_width)
    ) u_mac (
        .clk       (clk),
        .reset     (reset),
        .clr       (mac_clr_c),
        .en        (mac_en_c),
        .a         (act),
        .b         (wgt),
        .acc_nxt_c (acc_nxt_c)
    );

    // Next-state, counter and write-port logic; status outputs follow next state.
    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        pix_d     = pix_q;
        ch_d      = ch_q;
        ch_addr_d = ch_addr_q;
        addr_d    = addr_q;
        data_in_d = data_in_q;
        mac_clr_c = 1'b0;
        mac_en_c  = 1'b0;
        hs_c      = in_valid & in_ready_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_ACC;
                    tap_d     = '0;
                    pix_d     = '0;
                    ch_d      = '0;
                    mac_clr_c = 1'b1;
                end
            end
            ST_ACC: begin
                if (hs_c) begin
                    mac_en_c = 1'b1;
                    if (tap_q == TAP_LAST) begin
                        // Capture the completed sum including this last product.
                        tap_d     = '0;
                        state_d   = ST_WRITE;
                        data_in_d = acc_nxt_c;
                        ch_addr_d = ch_q;
                        addr_d    = pix_q;
                    end else begin
                        tap_d = tap_q + TAP_CW'(1);
                    end
                end
            end
            ST_WRITE: begin
                mac_clr_c = 1'b1;
                tap_d     = '0;
                if (pix_q == PIX_LAST) begin
                    pix_d = '0;
                    if (ch_q == CH_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        ch_d    = ch_q + CH_W'(1);
                        state_d = ST_ACC;
                    end
                end else begin
                    pix_d   = pix_q + PIX_W'(1);
                    state_d = ST_ACC;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d   = (state_d == ST_ACC);
        busy_d       = (state_d == ST_ACC) || (state_d == ST_WRITE);
        w_en_d       = (state_d == ST_WRITE);
        frame_done_d = (state_d == ST_DONE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            tap_q        <= '0;
            pix_q        <= '0;
            ch_q         <= '0;
            in_ready_q   <= 1'b0;
            w_en_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            ch_addr_q    <= '0;
            addr_q       <= '0;
            data_in_q    <= '0;
        end else begin
            state_q      <= state_d;
            tap_q        <= tap_d;
            pix_q        <= pix_d;
            ch_q         <= ch_d;
            in_ready_q   <= in_ready_d;
            w_en_q       <= w_en_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            ch_addr_q    <= ch_addr_d;
            addr_q       <= addr_d;
            data_in_q    <= data_in_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign w_en       = w_en_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign ch_addr    = ch_addr_q;
    assign addr       = addr_q;
    assign data_in    = data_in_q;

endmodule
